// File: rtl/riscv_pkg.sv
// Shared decode types for the RV32I decode stage: opcodes, control enums,
// the packed control bundle and the immediate extender.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef struct packed {
      logic        reg_write;
      result_src_t result_src;
      logic        mem_write;
      logic        jump;
      logic        branch;
      alu_ctrl_t   alu_ctrl;
      logic        alu_src;
      logic        illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

   function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                              input imm_src_t  src);
      logic [31:0] v_imm;
      v_imm = '0;
      case (src)
         IMM_I:   v_imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   v_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   v_imm = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
         default: v_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
      endcase
      return v_imm;
   endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports and one write port.
// x0 reads as zero; a same-cycle valid write is forwarded to the readers.
module regfile #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      i_rs1,
   input  logic [4:0]      i_rs2,
   input  logic            i_we,
   input  logic [4:0]      i_rd,
   input  logic [XLEN-1:0] i_wd,
   output logic [XLEN-1:0] o_rd1,
   output logic [XLEN-1:0] o_rd2
);

   logic [XLEN-1:0] w_rf [32];
   logic            w_wr_valid;

   assign w_wr_valid = i_we && (i_rd != 5'd0);

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_rf
         if (gi == 0) begin : g_zero
            assign w_rf[gi] = '0;
         end else begin : g_reg
            logic [XLEN-1:0] r_q;
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  r_q <= '0;
               end else if (w_wr_valid && (i_rd == 5'(gi))) begin
                  r_q <= i_wd;
               end
            end
            assign w_rf[gi] = r_q;
         end
      end
   endgenerate

   // Bypass lets decode see the value write-back is committing this edge.
   assign o_rd1 = (i_rs1 == 5'd0)                 ? '0   :
                  (w_wr_valid && (i_rd == i_rs1)) ? i_wd : w_rf[i_rs1];
   assign o_rd2 = (i_rs2 == 5'd0)                 ? '0   :
                  (w_wr_valid && (i_rd == i_rs2)) ? i_wd : w_rf[i_rs2];

endmodule

// File: rtl/idecode.sv
// RV32I decode stage: main/ALU decoder, immediate extension, register file
// read and the ID/EX pipeline register feeding execute.
module idecode
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic            IllegalE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE
);

   logic [6:0]      w_op;
   logic [2:0]      w_funct3;
   logic            w_funct7b5;
   logic [4:0]      w_rd;
   ctrl_t           w_ctrl;
   imm_src_t        w_imm_src;
   logic [1:0]      w_alu_op;
   logic [XLEN-1:0] w_imm_ext;
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;

   ctrl_t           r_ctrl;
   logic [XLEN-1:0] r_rd1;
   logic [XLEN-1:0] r_rd2;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc4;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [4:0]      r_rd;

   assign w_op       = InstrD[6:0];
   assign w_rd       = InstrD[11:7];
   assign w_funct3   = InstrD[14:12];
   assign w_funct7b5 = InstrD[30];
   assign Rs1D       = InstrD[19:15];
   assign Rs2D       = InstrD[24:20];

   always_comb begin
      w_ctrl    = CTRL_BUBBLE;
      w_imm_src = IMM_I;
      w_alu_op  = 2'b00;
      case (w_op)
         OP_LOAD: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.result_src = RES_MEM;
         end
         OP_STORE: begin
            w_ctrl.mem_write = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_imm_src        = IMM_S;
         end
         OP_RTYPE: begin
            w_ctrl.reg_write = 1'b1;
            w_alu_op         = 2'b10;
         end
         OP_IALU: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_alu_op         = 2'b10;
         end
         OP_BRANCH: begin
            w_ctrl.branch = 1'b1;
            w_imm_src     = IMM_B;
            w_alu_op      = 2'b01;
         end
         OP_JAL: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.jump       = 1'b1;
            w_ctrl.result_src = RES_PC4;
            w_imm_src         = IMM_J;
         end
         default: w_ctrl.illegal = 1'b1;
      endcase

      // I-ALU has op[5]=0, so an immediate with bit 30 set never selects sub.
      case (w_alu_op)
         2'b01: w_ctrl.alu_ctrl = ALU_SUB;
         2'b10: begin
            case (w_funct3)
               3'b000: w_ctrl.alu_ctrl = ({w_op[5], w_funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
               3'b010: w_ctrl.alu_ctrl = ALU_SLT;
               3'b110: w_ctrl.alu_ctrl = ALU_OR;
               3'b111: w_ctrl.alu_ctrl = ALU_AND;
               default: begin
                  w_ctrl.alu_ctrl = ALU_ADD;
                  w_ctrl.illegal  = 1'b1;
               end
            endcase
         end
         default: w_ctrl.alu_ctrl = ALU_ADD;
      endcase
   end

   assign w_imm_ext = imm_extend(InstrD, w_imm_src);

   regfile #(
      .XLEN (XLEN)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .i_rs1 (Rs1D),
      .i_rs2 (Rs2D),
      .i_we  (RegWriteW),
      .i_rd  (RdW),
      .i_wd  (ResultW),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl <= CTRL_BUBBLE;
         r_rd1  <= '0;
         r_rd2  <= '0;
         r_imm  <= '0;
         r_pc   <= '0;
         r_pc4  <= '0;
         r_rs1  <= '0;
         r_rs2  <= '0;
         r_rd   <= '0;
      end else if (FlushE) begin
         r_ctrl <= CTRL_BUBBLE;
         r_rd1  <= '0;
         r_rd2  <= '0;
         r_imm  <= '0;
         r_pc   <= '0;
         r_pc4  <= '0;
         r_rs1  <= '0;
         r_rs2  <= '0;
         r_rd   <= '0;
      end else begin
         r_ctrl <= w_ctrl;
         r_rd1  <= w_rd1;
         r_rd2  <= w_rd2;
         r_imm  <= w_imm_ext;
         r_pc   <= PCD;
         r_pc4  <= PCPlus4D;
         r_rs1  <= Rs1D;
         r_rs2  <= Rs2D;
         r_rd   <= w_rd;
      end
   end

   assign RegWriteE   = r_ctrl.reg_write;
   assign MemWriteE   = r_ctrl.mem_write;
   assign JumpE       = r_ctrl.jump;
   assign BranchE     = r_ctrl.branch;
   assign ALUSrcE     = r_ctrl.alu_src;
   assign IllegalE    = r_ctrl.illegal;
   assign ResultSrcE  = r_ctrl.result_src;
   assign ALUControlE = r_ctrl.alu_ctrl;
   assign RD1E        = r_rd1;
   assign RD2E        = r_rd2;
   assign ImmExtE     = r_imm;
   assign PCE         = r_pc;
   assign PCPlus4E    = r_pc4;
   assign Rs1E        = r_rs1;
   assign Rs2E        = r_rs2;
   assign RdE         = r_rd;

endmodule
